pc_fetch_stage: RTL and testbench

//  Pre-IF stage: owns the architectural fetch PC and issues requests on the SRAM-like

---
 rtl/cpuDefine.sv | 18 +
 rtl/fetch_perf_cnt.sv | 21 ++
 rtl/pc_fetch_stage.sv | 122 ++++++++++++
 tb/tb_pc_fetch_stage.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpuDefine.sv
// rtl/cpuDefine.sv - shared fetch-stage types, state encoding and reset PC.
package cpuDefine;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h1C00_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        adef;
  } IF_DATA;

  typedef enum logic [1:0] {
    FS_REQ  = 2'd0,
    FS_WAIT = 2'd1,
    FS_HOLD = 2'd2
  } FetchState;

endpackage

// File: rtl/fetch_perf_cnt.sv
// rtl/fetch_perf_cnt.sv - 32-bit event counter that sticks at all-ones.
module fetch_perf_cnt (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        inc_i,
  output logic [31:0] count_o
);

  logic [31:0] count_q;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      count_q <= 32'h0;
    end else if (inc_i && (count_q != 32'hFFFF_FFFF)) begin
      count_q <= count_q + 32'h1;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/pc_fetch_stage.sv
// rtl/pc_fetch_stage.sv - pre-IF stage: fetch PC, single-outstanding SRAM-like fetch.
// Optional FETCH_PERF_CNT_EN adds WAIT-cycle and dropped-response counters.
module pc_fetch_stage
  import cpuDefine::*;
#(
  parameter int                 ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              allow_in,
  output logic              inst_req,
  output logic [ADDR_W-1:0] inst_addr,
  input  logic              inst_addr_ok,
  input  logic              inst_data_ok,
  input  logic [31:0]       inst_rdata,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]       perf_wait_cycles,
  output logic [31:0]       perf_drop_cnt,
`endif
  output logic              valid_out,
  output IF_DATA            data_out
);

  FetchState         state_q;
  logic [ADDR_W-1:0] pc_q;
  logic              discard_q;
  IF_DATA            buf_q;
  logic              aligned;

  assign aligned = (pc_q[1:0] == 2'b00);

  // Outputs are forced quiet while reset is held, before the first edge loads state.
  assign inst_req  = aresetn && (state_q == FS_REQ) && aligned;
  assign inst_addr = pc_q;
  assign valid_out = aresetn && (state_q == FS_HOLD);
  assign data_out  = aresetn ? buf_q : '{pc: 32'(RESET_PC), inst: 32'h0, adef: 1'b0};

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q   <= FS_REQ;
      pc_q      <= RESET_PC;
      discard_q <= 1'b0;
      buf_q     <= '0;
    end else begin
      case (state_q)
        FS_REQ: begin
          if (redirect_valid) begin
            pc_q <= redirect_pc;
            // An accepted old-PC request still owes a response; mark it for dropping.
            if (inst_req && inst_addr_ok) begin
              state_q   <= FS_WAIT;
              discard_q <= 1'b1;
            end
          end else if (!aligned) begin
            buf_q   <= '{pc: 32'(pc_q), inst: 32'h0, adef: 1'b1};
            state_q <= FS_HOLD;
          end else if (inst_addr_ok) begin
            state_q <= FS_WAIT;
          end
        end
        FS_WAIT: begin
          if (redirect_valid) begin
            pc_q <= redirect_pc;
          end
          if (inst_data_ok) begin
            if (redirect_valid || discard_q) begin
              discard_q <= 1'b0;
              state_q   <= FS_REQ;
            end else begin
              buf_q   <= '{pc: 32'(pc_q), inst: inst_rdata, adef: 1'b0};
              state_q <= FS_HOLD;
            end
          end else if (redirect_valid) begin
            discard_q <= 1'b1;
          end
        end
        FS_HOLD: begin
          if (redirect_valid) begin
            pc_q    <= redirect_pc;
            state_q <= FS_REQ;
          end else if (allow_in) begin
            pc_q    <= pc_q + ADDR_W'(4);
            state_q <= FS_REQ;
          end
        end
        default: state_q <= FS_REQ;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic drop_evt;
  assign drop_evt = (state_q == FS_WAIT) && inst_data_ok && (redirect_valid || discard_q);

  fetch_perf_cnt u_wait_cnt (
    .aclk    (aclk),
    .aresetn (aresetn),
    .inc_i   (state_q == FS_WAIT),
    .count_o (perf_wait_cycles)
  );

  fetch_perf_cnt u_drop_cnt (
    .aclk    (aclk),
    .aresetn (aresetn),
    .inc_i   (drop_evt),
    .count_o (perf_drop_cnt)
  );
`endif

`ifndef SYNTHESIS
  // A response with nothing outstanding is a slave protocol error.
  always_ff @(posedge aclk) begin
    if (aresetn) begin
      assert (!(inst_data_ok && (state_q != FS_WAIT)));
    end
  end
`endif

endmodule

// File: tb/tb_pc_fetch_stage.sv
// tb/tb_pc_fetch_stage.sv - directed self-checking bench for pc_fetch_stage.
module tb_pc_fetch_stage;
  import cpuDefine::*;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        allow_in;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        valid_out;
  IF_DATA      data_out;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_wait_cycles;
  logic [31:0] perf_drop_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 aclk = ~aclk;

  pc_fetch_stage dut (
    .aclk           (aclk),
    .aresetn        (aresetn),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .allow_in       (allow_in),
    .inst_req       (inst_req),
    .inst_addr      (inst_addr),
    .inst_addr_ok   (inst_addr_ok),
    .inst_data_ok   (inst_data_ok),
    .inst_rdata     (inst_rdata),
`ifdef FETCH_PERF_CNT_EN
    .perf_wait_cycles (perf_wait_cycles),
    .perf_drop_cnt    (perf_drop_cnt),
`endif
    .valid_out      (valid_out),
    .data_out       (data_out)
  );

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Drives one fetch from REQ into HOLD and checks the packed result.
  task automatic get_to_hold(input logic [31:0] exp_addr, input logic [31:0] rd);
    IF_DATA exp;
    int n = 0;
    while (!inst_req && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (inst_req !== 1'b1 || inst_addr !== exp_addr) begin
      failures++;
      $display("FAIL req_addr: req=%b addr=%h required req=1 addr=%h", inst_req, inst_addr, exp_addr);
    end
    inst_addr_ok = 1'b1;
    tick();
    inst_addr_ok = 1'b0;
    checks++;
    if (inst_req !== 1'b0 || valid_out !== 1'b0) begin
      failures++;
      $display("FAIL wait_quiet: req=%b valid=%b required 0 0", inst_req, valid_out);
    end
    inst_data_ok = 1'b1;
    inst_rdata   = rd;
    tick();
    inst_data_ok = 1'b0;
    exp = '{pc: exp_addr, inst: rd, adef: 1'b0};
    checks++;
    if (valid_out !== 1'b1 || data_out !== exp) begin
      failures++;
      $display("FAIL hold_data: valid=%b data=%h required valid=1 data=%h", valid_out, data_out, exp);
    end
  endtask

  task automatic test_reset();
    IF_DATA exp;
    aresetn = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; allow_in = 1'b0;
    inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = 32'h0;
    #1;
    exp = '{pc: 32'h1C00_0000, inst: 32'h0, adef: 1'b0};
    checks++;
    if (inst_req !== 1'b0 || valid_out !== 1'b0 || data_out !== exp) begin
      failures++;
      $display("FAIL reset_pre_edge: req=%b valid=%b data=%h required 0 0 %h", inst_req, valid_out, data_out, exp);
    end
    tick(); tick();
    checks++;
    if (inst_req !== 1'b0 || valid_out !== 1'b0 || data_out !== exp) begin
      failures++;
      $display("FAIL reset_held: req=%b valid=%b data=%h required 0 0 %h", inst_req, valid_out, data_out, exp);
    end
    aresetn = 1'b1;
    #1;
    checks++;
    if (inst_req !== 1'b1 || inst_addr !== 32'h1C00_0000) begin
      failures++;
      $display("FAIL reset_release: req=%b addr=%h required 1 1c000000", inst_req, inst_addr);
    end
  endtask

  task automatic test_sequential();
    allow_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      get_to_hold(32'h1C00_0000 + 32'(i * 4), 32'hA000_0000 + 32'(i));
      tick();
    end
  endtask

  task automatic test_stall();
    IF_DATA exp;
    allow_in = 1'b0;
    get_to_hold(32'h1C00_000C, 32'h1234_5678);
    exp = '{pc: 32'h1C00_000C, inst: 32'h1234_5678, adef: 1'b0};
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (valid_out !== 1'b1 || data_out !== exp || inst_req !== 1'b0 || inst_addr !== 32'h1C00_000C) begin
        failures++;
        $display("FAIL stall_hold[%0d]: valid=%b data=%h req=%b addr=%h required 1 %h 0 1c00000c",
                 i, valid_out, data_out, inst_req, inst_addr, exp);
      end
    end
    allow_in = 1'b1;
    tick();
    checks++;
    if (inst_req !== 1'b1 || inst_addr !== 32'h1C00_0010) begin
      failures++;
      $display("FAIL stall_release: req=%b addr=%h required 1 1c000010", inst_req, inst_addr);
    end
  endtask

  task automatic test_redirect_wait();
    logic seen_bad = 1'b0;
    allow_in = 1'b1;
    inst_addr_ok = 1'b1;
    tick();
    inst_addr_ok = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h1C00_0100;
    tick();
    redirect_valid = 1'b0;
    tick(); tick();
    inst_data_ok = 1'b1;
    inst_rdata   = 32'hDEAD_BEEF;
    tick();
    inst_data_ok = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (valid_out && data_out.inst == 32'hDEAD_BEEF) seen_bad = 1'b1;
      if (i < 2) #2;
    end
    checks++;
    if (seen_bad || valid_out !== 1'b0 || inst_req !== 1'b1 || inst_addr !== 32'h1C00_0100) begin
      failures++;
      $display("FAIL redirect_wait: bad=%b valid=%b req=%b addr=%h required 0 0 1 1c000100",
               seen_bad, valid_out, inst_req, inst_addr);
    end
`ifdef FETCH_PERF_CNT_EN
    checks++;
    if (perf_drop_cnt !== 32'd1) begin
      failures++;
      $display("FAIL perf_drop: cnt=%0d required 1", perf_drop_cnt);
    end
`endif
    get_to_hold(32'h1C00_0100, 32'h0BAD_F00D);
    tick();
  endtask

  task automatic test_redirect_addr_ok();
    allow_in = 1'b1;
    checks++;
    if (inst_req !== 1'b1 || inst_addr !== 32'h1C00_0104) begin
      failures++;
      $display("FAIL redir_aok_pre: req=%b addr=%h required 1 1c000104", inst_req, inst_addr);
    end
    inst_addr_ok = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h1C00_0200;
    tick();
    inst_addr_ok = 1'b0;
    redirect_valid = 1'b0;
    checks++;
    if (inst_req !== 1'b0) begin
      failures++;
      $display("FAIL redir_aok_wait: req=%b required 0", inst_req);
    end
    inst_data_ok = 1'b1;
    inst_rdata   = 32'hBAD0_BAD0;
    tick();
    inst_data_ok = 1'b0;
    checks++;
    if (valid_out !== 1'b0 || inst_req !== 1'b1 || inst_addr !== 32'h1C00_0200) begin
      failures++;
      $display("FAIL redir_aok_drop: valid=%b req=%b addr=%h required 0 1 1c000200", valid_out, inst_req, inst_addr);
    end
    get_to_hold(32'h1C00_0200, 32'h5555_AAAA);
    tick();
  endtask

  task automatic test_misaligned();
    IF_DATA exp;
    allow_in = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h1C00_0102;
    tick();
    redirect_valid = 1'b0;
    checks++;
    if (inst_req !== 1'b0 || inst_addr !== 32'h1C00_0102) begin
      failures++;
      $display("FAIL misalign_req: req=%b addr=%h required 0 1c000102", inst_req, inst_addr);
    end
    tick();
    exp = '{pc: 32'h1C00_0102, inst: 32'h0, adef: 1'b1};
    checks++;
    if (valid_out !== 1'b1 || data_out !== exp || inst_req !== 1'b0) begin
      failures++;
      $display("FAIL misalign_adef: valid=%b data=%h req=%b required 1 %h 0", valid_out, data_out, inst_req, exp);
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h1C00_0300;
    tick();
    redirect_valid = 1'b0;
    checks++;
    if (valid_out !== 1'b0 || inst_req !== 1'b1 || inst_addr !== 32'h1C00_0300) begin
      failures++;
      $display("FAIL misalign_recover: valid=%b req=%b addr=%h required 0 1 1c000300", valid_out, inst_req, inst_addr);
    end
  endtask

  task automatic test_reset_mid();
    allow_in = 1'b1;
    inst_addr_ok = 1'b1;
    tick();
    inst_addr_ok = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h1C00_0400;
    tick();
    redirect_valid = 1'b0;
    aresetn = 1'b0;
    #1;
    checks++;
    if (inst_req !== 1'b0 || valid_out !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_out: req=%b valid=%b required 0 0", inst_req, valid_out);
    end
    tick();
    aresetn = 1'b1;
    #1;
    checks++;
    if (inst_req !== 1'b1 || inst_addr !== 32'h1C00_0000) begin
      failures++;
      $display("FAIL reset_mid_pc: req=%b addr=%h required 1 1c000000", inst_req, inst_addr);
    end
`ifdef FETCH_PERF_CNT_EN
    checks++;
    if (perf_drop_cnt !== 32'd0 || perf_wait_cycles !== 32'd0) begin
      failures++;
      $display("FAIL reset_mid_perf: drop=%0d wait=%0d required 0 0", perf_drop_cnt, perf_wait_cycles);
    end
`endif
    get_to_hold(32'h1C00_0000, 32'hC0FF_EE00);
    tick();
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_wait();
    test_redirect_addr_ok();
    test_misaligned();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
